// File: rtl/dbus_ram_responder_if.sv
// Data-bus interface between an initiator and the RAM responder.
//   dreq  : request  - valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]
//   dresp : response - addr_ok, data_ok, data[63:0]
// Modports: master (initiator side), slave (responder side).
interface dbus_ram_responder_if;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_ram_responder.sv
// Fixed-latency 64-bit RAM responder on the data bus.
// Accepts one request in IDLE, completes it LATENCY cycles later with a
// one-cycle addr_ok/data_ok pulse carrying the pre-write word, then returns
// to IDLE. Out-of-range requests return 0, never write, and pulse err.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous, active-high
//   bus     : data-bus slave (dreq in, dresp out)
//   err     : out-of-range flag, coincident with data_ok
//   txn_cnt : completed-transaction count, wraps
module dbus_ram_responder #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  dbus_ram_responder_if.slave  bus,
  output logic                 err,
  output logic [31:0]          txn_cnt
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] SPAN      = 64'(DEPTH_WORDS) << 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam bit          SKIP_WAIT = (LATENCY <= 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        strobe_q;
  logic [63:0]       wdata_q;
  logic              in_range_q;

  logic [63:0]       mem [DEPTH_WORDS];

  logic [63:0]       offset_c;
  logic              in_range_c;
  logic [IDX_W-1:0]  idx_c;
  logic              accept_c;

  logic [IDX_W-1:0]  rd_idx_c;
  logic              rd_in_range_c;
  logic              resp_ok_next;
  logic [63:0]       resp_data_next;
  logic              err_next;

  logic              unused_bits;

  // Decode of the live request address; low 3 bits drop out of the index.
  assign offset_c    = bus.dreq.addr - BASE_ADDR;
  assign in_range_c  = (bus.dreq.addr >= BASE_ADDR) && (offset_c < SPAN);
  assign idx_c       = offset_c[IDX_W+2:3];
  assign accept_c    = (state == IDLE) && bus.dreq.valid;
  assign unused_bits = ^{offset_c, bus.dreq.size};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.dreq.valid) state_next = SKIP_WAIT ? RESP : WAIT;
      WAIT:    if (cnt <= CNT_W'(1)) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latency counter and captured request; later dreq changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx_q      <= '0;
      strobe_q   <= '0;
      wdata_q    <= '0;
      in_range_q <= 1'b0;
    end else if (accept_c) begin
      cnt        <= CNT_LOAD;
      idx_q      <= idx_c;
      strobe_q   <= bus.dreq.strobe;
      wdata_q    <= bus.dreq.data;
      in_range_q <= in_range_c;
    end else if (state == WAIT) begin
      cnt        <= cnt - CNT_W'(1);
    end
  end

  // Output logic: response values for the coming cycle. With LATENCY=1 RESP
  // is entered straight from IDLE, so the read uses the live address.
  always_comb begin
    rd_idx_c       = (state == IDLE) ? idx_c : idx_q;
    rd_in_range_c  = (state == IDLE) ? in_range_c : in_range_q;
    resp_ok_next   = 1'b0;
    resp_data_next = '0;
    err_next       = 1'b0;
    if (state_next == RESP) begin
      resp_ok_next = 1'b1;
      if (rd_in_range_c) resp_data_next = mem[rd_idx_c];
      else               err_next       = 1'b1;
    end
  end

  // Registered response; the word is read on the edge entering RESP, which is
  // before the RESP-edge write of the same transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dresp <= '0;
      err       <= 1'b0;
    end else begin
      bus.dresp.addr_ok <= resp_ok_next;
      bus.dresp.data_ok <= resp_ok_next;
      bus.dresp.data    <= resp_data_next;
      err               <= err_next;
    end
  end

  // Completed-transaction counter
  always_ff @(posedge clk) begin
    if (reset)              txn_cnt <= '0;
    else if (state == RESP) txn_cnt <= txn_cnt + 32'd1;
  end

  // Byte-masked write on the RESP edge; never cleared, suppressed by reset.
  always_ff @(posedge clk) begin
    if (!reset && (state == RESP) && in_range_q) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Self-checking bench for dbus_ram_responder: directed vector table, randomized
// traffic against a word-array model, and multi-cycle corner sequences.
module tb_dbus_ram_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int unsigned DEPTH = 4096;
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic        err_a, err_b, err_c;
  logic [31:0] cnt_a, cnt_b, cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbus_ram_responder_if ia ();
  dbus_ram_responder_if ib ();
  dbus_ram_responder_if ic ();

  dbus_ram_responder #(.LATENCY(2), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) u_a (
    .clk(clk), .reset(rst_a), .bus(ia), .err(err_a), .txn_cnt(cnt_a));
  dbus_ram_responder #(.LATENCY(1), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) u_b (
    .clk(clk), .reset(rst_b), .bus(ib), .err(err_b), .txn_cnt(cnt_b));
  dbus_ram_responder #(.LATENCY(4), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) u_c (
    .clk(clk), .reset(rst_c), .bus(ic), .err(err_c), .txn_cnt(cnt_c));

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wd;
    bit          chk;
    logic [63:0] exp;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [63:0] addr, input logic [7:0] strb, input logic [63:0] wd,
                         input bit chk, input logic [63:0] exp, input bit exp_err);
    vec_t v;
    v.addr = addr; v.strb = strb; v.wd = wd; v.chk = chk; v.exp = exp; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // One transaction on the LATENCY=2 instance; dreq is scrambled after acceptance.
  task automatic run_a(input logic [63:0] addr, input logic [7:0] strb, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er, output logic aok, output int lat,
                       output logic [31:0] cnt_after, output logic ok_after);
    @(negedge clk);
    ia.dreq.valid  = 1'b1;
    ia.dreq.addr   = addr;
    ia.dreq.size   = 3'd3;
    ia.dreq.strobe = strb;
    ia.dreq.data   = wd;
    @(posedge clk);
    #1;
    ia.dreq.valid  = 1'b0;
    ia.dreq.addr   = {$urandom, $urandom};
    ia.dreq.size   = 3'($urandom);
    ia.dreq.strobe = 8'($urandom);
    ia.dreq.data   = {$urandom, $urandom};
    rd = '0; er = 1'b0; aok = 1'b0; lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ia.dresp.data_ok === 1'b1) begin
        lat = k; rd = ia.dresp.data; er = err_a; aok = ia.dresp.addr_ok;
        break;
      end
      check1("quiet_a", (ia.dresp.addr_ok === 1'b0) && (ia.dresp.data === 64'd0) && (err_a === 1'b0), 1'b1);
    end
    @(negedge clk);
    cnt_after = cnt_a;
    ok_after  = ia.dresp.data_ok;
  endtask

  // One transaction on the LATENCY=4 instance.
  task automatic run_c(input logic [63:0] addr, input logic [7:0] strb, input logic [63:0] wd,
                       output logic [63:0] rd, output int lat);
    @(negedge clk);
    ic.dreq.valid  = 1'b1;
    ic.dreq.addr   = addr;
    ic.dreq.size   = 3'd3;
    ic.dreq.strobe = strb;
    ic.dreq.data   = wd;
    @(posedge clk);
    #1;
    ic.dreq.valid  = 1'b0;
    rd = '0; lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ic.dresp.data_ok === 1'b1) begin
        lat = k; rd = ic.dresp.data;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        er, aok, ok_after;
    logic [31:0] cnt_after;
    int          lat;
    logic [31:0] exp_cnt;
    logic [63:0] mdl [16];
    logic [63:0] d1, v1, v2;

    ia.dreq = '0;
    ib.dreq = '0;
    ic.dreq = '0;

    // Reset state of the LATENCY=2 instance
    repeat (2) @(negedge clk);
    check64("rst_data", ia.dresp.data, 64'd0);
    check1("rst_ok", ia.dresp.data_ok | ia.dresp.addr_ok | err_a, 1'b0);
    check64("rst_cnt", 64'(cnt_a), 64'd0);
    rst_a = 1'b0;
    @(negedge clk);
    check1("post_rst_ok", ia.dresp.data_ok, 1'b0);

    // Directed vectors
    add_vec(64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 0, 64'd0, 0);
    add_vec(64'h8000_0010, 8'h00, 64'd0,                   1, 64'h1122_3344_5566_7788, 0);
    add_vec(64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 1, 64'h1122_3344_5566_7788, 0);
    add_vec(64'h8000_0010, 8'h00, 64'd0,                   1, 64'h1122_3344_BBBB_BBBB, 0);
    add_vec(64'h8000_0000, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, 0, 64'd0, 0);
    add_vec(64'h7FFF_FFF8, 8'h00, 64'd0,                   1, 64'd0, 1);
    add_vec(64'h8000_8000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1, 64'd0, 1);
    add_vec(64'h8000_0000, 8'h00, 64'd0,                   1, 64'h5A5A_5A5A_5A5A_5A5A, 0);
    add_vec(64'h8000_7FF8, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 64'd0, 0);
    add_vec(64'h8000_7FFF, 8'h00, 64'd0,                   1, 64'h0123_4567_89AB_CDEF, 0);
    add_vec(64'h8000_0017, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h1122_3344_BBBB_BBBB, 0);
    add_vec(64'h8000_0010, 8'h81, 64'hEE00_0000_0000_00DD, 1, 64'h1122_3344_BBBB_BBBB, 0);
    add_vec(64'h8000_0010, 8'h00, 64'd0,                   1, 64'hEE22_3344_BBBB_BBDD, 0);

    exp_cnt = 32'd0;
    foreach (vecs[i]) begin
      run_a(vecs[i].addr, vecs[i].strb, vecs[i].wd, rd, er, aok, lat, cnt_after, ok_after);
      exp_cnt++;
      check64($sformatf("vec%0d_lat", i), 64'(lat), 64'd2);
      check1($sformatf("vec%0d_addr_ok", i), aok, 1'b1);
      check1($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      if (vecs[i].chk) check64($sformatf("vec%0d_data", i), rd, vecs[i].exp);
      check64($sformatf("vec%0d_cnt", i), 64'(cnt_after), 64'(exp_cnt));
      check1($sformatf("vec%0d_single", i), ok_after, 1'b0);
    end

    // Randomized traffic against a word-array model of words 0..15
    for (int w = 0; w < 16; w++) begin
      mdl[w] = {$urandom, $urandom};
      run_a(BASE + 64'(8 * w), 8'hFF, mdl[w], rd, er, aok, lat, cnt_after, ok_after);
      exp_cnt++;
    end
    check64("init_cnt", 64'(cnt_after), 64'(exp_cnt));
    for (int n = 0; n < 60; n++) begin
      logic [63:0] addr, wd, exp;
      logic [7:0]  strb;
      bit          oor;
      int          w;
      oor  = ($urandom_range(0, 7) == 0);
      wd   = {$urandom, $urandom};
      strb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      w    = $urandom_range(0, 15);
      if (oor) begin
        if ($urandom_range(0, 1) == 0) addr = BASE - 64'(8 * $urandom_range(1, 100)) + 64'($urandom_range(0, 7));
        else                           addr = BASE + SPAN + 64'($urandom_range(0, 1000));
        exp = 64'd0;
      end else begin
        addr = BASE + 64'(8 * w) + 64'($urandom_range(0, 7));
        exp  = mdl[w];
        for (int b = 0; b < 8; b++)
          if (strb[b]) mdl[w][8*b +: 8] = wd[8*b +: 8];
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_a(addr, strb, wd, rd, er, aok, lat, cnt_after, ok_after);
      exp_cnt++;
      check64($sformatf("rnd%0d_data", n), rd, exp);
      check1($sformatf("rnd%0d_err", n), er, oor);
      check64($sformatf("rnd%0d_lat", n), 64'(lat), 64'd2);
      check64($sformatf("rnd%0d_cnt", n), 64'(cnt_after), 64'(exp_cnt));
      check1($sformatf("rnd%0d_single", n), ok_after, 1'b0);
    end

    // LATENCY=1: valid held high through reset release and three requests
    d1 = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    ib.dreq.valid  = 1'b1;
    ib.dreq.addr   = BASE + 64'h100;
    ib.dreq.size   = 3'd3;
    ib.dreq.strobe = 8'hFF;
    ib.dreq.data   = d1;
    @(negedge clk);
    check1("l1_rst_hold", ib.dresp.data_ok, 1'b0);
    rst_b = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check1($sformatf("l1_ok_c%0d", k), ib.dresp.data_ok, 1'(k % 2));
      if (k == 3 || k == 5) check64($sformatf("l1_data_c%0d", k), ib.dresp.data, d1);
      if (k == 5) ib.dreq.valid = 1'b0;
    end
    check64("l1_cnt", 64'(cnt_b), 64'd3);
    check1("l1_err", err_b, 1'b0);

    // LATENCY=4: reset in WAIT abandons the write
    v1 = 64'h0F0F_0F0F_1111_2222;
    v2 = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    rst_c = 1'b0;
    run_c(BASE + 64'h200, 8'hFF, v1, rd, lat);
    check64("l4_lat_w", 64'(lat), 64'd4);
    check64("l4_cnt1", 64'(cnt_c), 64'd1);
    @(negedge clk);
    ic.dreq.valid  = 1'b1;
    ic.dreq.addr   = BASE + 64'h200;
    ic.dreq.strobe = 8'hFF;
    ic.dreq.data   = v2;
    @(posedge clk);
    #1;
    ic.dreq.valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_c = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check1($sformatf("l4_abandon_c%0d", k), ic.dresp.data_ok, 1'b0);
      if (k == 2) rst_c = 1'b0;
    end
    check64("l4_cnt_rst", 64'(cnt_c), 64'd0);
    run_c(BASE + 64'h200, 8'h00, 64'd0, rd, lat);
    check64("l4_lat_r", 64'(lat), 64'd4);
    check64("l4_unchanged", rd, v1);
    check64("l4_cnt2", 64'(cnt_c), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
